// File: rtl/arm_ctrl_pkg.sv
// Shared definitions for the ARM data-processing control slice.
// Provides the sequencer state encoding, ARM condition-code values,
// instruction field positions and NZCV flag bit positions.
package arm_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        LATCH,
        EXEC
    } seq_state_t;

    // ARM condition field encodings
    localparam logic [3:0] COND_EQ = 4'h0;
    localparam logic [3:0] COND_NE = 4'h1;
    localparam logic [3:0] COND_CS = 4'h2;
    localparam logic [3:0] COND_CC = 4'h3;
    localparam logic [3:0] COND_MI = 4'h4;
    localparam logic [3:0] COND_PL = 4'h5;
    localparam logic [3:0] COND_VS = 4'h6;
    localparam logic [3:0] COND_VC = 4'h7;
    localparam logic [3:0] COND_HI = 4'h8;
    localparam logic [3:0] COND_LS = 4'h9;
    localparam logic [3:0] COND_GE = 4'hA;
    localparam logic [3:0] COND_LT = 4'hB;
    localparam logic [3:0] COND_GT = 4'hC;
    localparam logic [3:0] COND_LE = 4'hD;
    localparam logic [3:0] COND_AL = 4'hE;

    // Instruction field positions
    localparam int unsigned COND_MSB = 31;
    localparam int unsigned COND_LSB = 28;
    localparam int unsigned S_BIT    = 20;

    // NZCV bit positions within a 4-bit flag vector
    localparam int unsigned FLAG_N = 3;
    localparam int unsigned FLAG_Z = 2;
    localparam int unsigned FLAG_C = 1;
    localparam int unsigned FLAG_V = 0;

endpackage

// File: rtl/arm_cond_check.sv
// ARM condition-code evaluator (combinational).
// Ports:
//   cond  - 4-bit condition field from the instruction
//   nzcv  - current flags, bits [3:0] = N,Z,C,V
//   pass  - high when the condition holds (code 4'hF is treated as always)
module arm_cond_check
    import arm_ctrl_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] nzcv,
    output logic       pass
);

    logic n, z, c, v;

    assign n = nzcv[FLAG_N];
    assign z = nzcv[FLAG_Z];
    assign c = nzcv[FLAG_C];
    assign v = nzcv[FLAG_V];

    always_comb begin
        pass = 1'b1;
        case (cond)
            COND_EQ: pass = z;
            COND_NE: pass = !z;
            COND_CS: pass = c;
            COND_CC: pass = !c;
            COND_MI: pass = n;
            COND_PL: pass = !n;
            COND_VS: pass = v;
            COND_VC: pass = !v;
            COND_HI: pass = c && !z;
            COND_LS: pass = !c || z;
            COND_GE: pass = (n == v);
            COND_LT: pass = (n != v);
            COND_GT: pass = !z && (n == v);
            COND_LE: pass = z || (n != v);
            default: pass = 1'b1;
        endcase
    end

endmodule

// File: rtl/arm_dp_sequencer.sv
// Fetch/issue sequencer for the ARM_DataProcessing datapath.
// Each instruction goes FETCH -> LATCH -> EXEC (3 cycles without pause).
// Ports:
//   clk, reset            - clock, synchronous active-high reset
//   start, pause          - begin program (IDLE only) / hold in FETCH
//   prog_len              - instruction count 0..2**ADDR_W, captured on start
//   imem_en/addr/rdata    - synchronous-read instruction memory interface
//   Instr, exec_en        - registered instruction and one-cycle execute enable
//   alu_flags, flags      - datapath NZCV in / architectural NZCV out
//   busy, done            - not-IDLE status / completion pulse
//   issued_cnt/skipped_cnt- executed / condition-suppressed instruction counts
module arm_dp_sequencer
    import arm_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              pause,
    input  logic [ADDR_W:0]   prog_len,
    output logic              imem_en,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [DATA_W-1:0] imem_rdata,
    output logic [DATA_W-1:0] Instr,
    output logic              exec_en,
    input  logic [3:0]        alu_flags,
    output logic [3:0]        flags,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W:0]   issued_cnt,
    output logic [ADDR_W:0]   skipped_cnt
);

    localparam logic [ADDR_W:0] CNT_ONE = 1;

    seq_state_t        state_q, state_d;
    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W:0]   len_q;
    logic [DATA_W-1:0] instr_q;
    logic [3:0]        flags_q;
    logic              pass_q;
    logic              done_q;
    logic [ADDR_W:0]   issued_q;
    logic [ADDR_W:0]   skipped_q;

    logic              cond_pass;
    logic [ADDR_W:0]   pc_inc;
    logic              last_instr;

    // Condition is evaluated on the word arriving in LATCH against the flags
    // as they stand then; the result is held for the EXEC cycle.
    arm_cond_check u_cond (
        .cond (imem_rdata[COND_MSB:COND_LSB]),
        .nzcv (flags_q),
        .pass (cond_pass)
    );

    // Extended by one bit so a full 2**ADDR_W program terminates correctly.
    assign pc_inc     = {1'b0, pc_q} + CNT_ONE;
    assign last_instr = (pc_inc == len_q);

    // State register
    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start && (prog_len != '0)) state_d = FETCH;
            FETCH:   if (!pause) state_d = LATCH;
            LATCH:   state_d = EXEC;
            EXEC:    state_d = last_instr ? IDLE : FETCH;
            default: state_d = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        imem_en     = (state_q == FETCH) && !pause;
        exec_en     = (state_q == EXEC) && pass_q;
        busy        = (state_q != IDLE);
        imem_addr   = pc_q;
        Instr       = instr_q;
        flags       = flags_q;
        done        = done_q;
        issued_cnt  = issued_q;
        skipped_cnt = skipped_q;
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q      <= '0;
            len_q     <= '0;
            instr_q   <= '0;
            flags_q   <= '0;
            pass_q    <= 1'b0;
            done_q    <= 1'b0;
            issued_q  <= '0;
            skipped_q <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        pc_q      <= '0;
                        len_q     <= prog_len;
                        issued_q  <= '0;
                        skipped_q <= '0;
                        if (prog_len == '0) done_q <= 1'b1;
                    end
                end
                LATCH: begin
                    instr_q <= imem_rdata;
                    pass_q  <= cond_pass;
                end
                EXEC: begin
                    pc_q <= pc_inc[ADDR_W-1:0];
                    if (pass_q) begin
                        issued_q <= issued_q + CNT_ONE;
                        if (instr_q[S_BIT]) flags_q <= alu_flags;
                    end else begin
                        skipped_q <= skipped_q + CNT_ONE;
                    end
                    if (last_instr) done_q <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_arm_dp_sequencer.sv
module tb_arm_dp_sequencer;

    localparam int ADDR_W = 8;

    logic              clk;
    logic              reset;
    logic              start;
    logic              pause;
    logic [ADDR_W:0]   prog_len;
    logic              imem_en;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_rdata;
    logic [31:0]       Instr;
    logic              exec_en;
    logic [3:0]        alu_flags;
    logic [3:0]        flags;
    logic              busy;
    logic              done;
    logic [ADDR_W:0]   issued_cnt;
    logic [ADDR_W:0]   skipped_cnt;

    arm_dp_sequencer #(.ADDR_W(ADDR_W), .DATA_W(32)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .pause       (pause),
        .prog_len    (prog_len),
        .imem_en     (imem_en),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .Instr       (Instr),
        .exec_en     (exec_en),
        .alu_flags   (alu_flags),
        .flags       (flags),
        .busy        (busy),
        .done        (done),
        .issued_cnt  (issued_cnt),
        .skipped_cnt (skipped_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Synchronous-read instruction memory
    logic [31:0] mem [256];
    always @(posedge clk) if (imem_en) imem_rdata <= mem[imem_addr];

    // Datapath flag stand-in: either a fixed value or the low nibble of Instr
    logic       alu_mode;
    logic [3:0] alu_fixed;
    assign alu_flags = alu_mode ? Instr[3:0] : alu_fixed;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic cond_model(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cy, v;
        n = f[3]; z = f[2]; cy = f[1]; v = f[0];
        case (c)
            4'h0: return z;
            4'h1: return !z;
            4'h2: return cy;
            4'h3: return !cy;
            4'h4: return n;
            4'h5: return !n;
            4'h6: return v;
            4'h7: return !v;
            4'h8: return cy & !z;
            4'h9: return !cy | z;
            4'hA: return n == v;
            4'hB: return n != v;
            4'hC: return !z & (n == v);
            4'hD: return z | (n != v);
            default: return 1'b1;
        endcase
    endfunction

    // Per-instruction observations from run_prog
    logic        rec_exec  [256];
    logic [31:0] rec_instr [256];
    logic [3:0]  rec_flags [256];
    logic        rec_done  [256];
    logic        rec_done_after;

    // Start a program and sample each EXEC cycle (3k+3 after start) and the
    // cycle after it; with no pause the timing is fixed so no wait is open-ended.
    task automatic run_prog(input int len);
        @(negedge clk);
        prog_len = (ADDR_W+1)'(len);
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < len; k++) begin
            @(negedge clk);
            @(negedge clk);
            rec_exec[k]  = exec_en;
            rec_instr[k] = Instr;
            @(negedge clk);
            rec_flags[k] = flags;
            rec_done[k]  = done;
        end
        @(negedge clk);
        rec_done_after = done;
    endtask

    typedef struct {
        logic [31:0] word;
        logic        exp_exec;
        logic [3:0]  exp_flags;
    } vec_t;

    vec_t t1 [3];
    vec_t t2 [3];

    initial begin
        reset = 1'b1; start = 1'b0; pause = 1'b0; prog_len = '0;
        alu_mode = 1'b0; alu_fixed = 4'h0;
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;

        t1[0] = '{32'hE2811001, 1'b1, 4'h0};
        t1[1] = '{32'hE2822002, 1'b1, 4'h0};
        t1[2] = '{32'hE0813002, 1'b1, 4'h0};
        t2[0] = '{32'hE2522001, 1'b1, 4'h4};
        t2[1] = '{32'h02811001, 1'b1, 4'h4};
        t2[2] = '{32'h12811001, 1'b0, 4'h4};

        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_exec", 32'(exec_en), 32'h0);
        chk("rst_imem_en", 32'(imem_en), 32'h0);
        chk("rst_done", 32'(done), 32'h0);
        chk("rst_flags", 32'(flags), 32'h0);
        chk("rst_instr", Instr, 32'h0);
        chk("rst_addr", 32'(imem_addr), 32'h0);
        chk("rst_issued", 32'(issued_cnt), 32'h0);
        chk("rst_skipped", 32'(skipped_cnt), 32'h0);
        reset = 1'b0;

        // Test 1: three AL instructions
        for (int i = 0; i < 3; i++) mem[i] = t1[i].word;
        run_prog(3);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("t1_exec%0d", i), 32'(rec_exec[i]), 32'(t1[i].exp_exec));
            chk($sformatf("t1_instr%0d", i), rec_instr[i], t1[i].word);
            chk($sformatf("t1_done%0d", i), 32'(rec_done[i]), (i == 2) ? 32'h1 : 32'h0);
        end
        chk("t1_done_pulse", 32'(rec_done_after), 32'h0);
        chk("t1_issued", 32'(issued_cnt), 32'd3);
        chk("t1_skipped", 32'(skipped_cnt), 32'd0);

        // Test 2: S-update feeds the next instruction's condition
        alu_fixed = 4'h4;
        for (int i = 0; i < 3; i++) mem[i] = t2[i].word;
        run_prog(3);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("t2_exec%0d", i), 32'(rec_exec[i]), 32'(t2[i].exp_exec));
            chk($sformatf("t2_flags%0d", i), 32'(rec_flags[i]), 32'(t2[i].exp_flags));
        end
        chk("t2_issued", 32'(issued_cnt), 32'd2);
        chk("t2_skipped", 32'(skipped_cnt), 32'd1);

        // Test 3: empty program
        @(negedge clk);
        prog_len = '0; start = 1'b1;
        chk("t3_imem_en_c0", 32'(imem_en), 32'h0);
        @(negedge clk);
        start = 1'b0;
        chk("t3_done", 32'(done), 32'h1);
        chk("t3_busy", 32'(busy), 32'h0);
        chk("t3_imem_en", 32'(imem_en), 32'h0);
        chk("t3_issued", 32'(issued_cnt), 32'h0);
        chk("t3_skipped", 32'(skipped_cnt), 32'h0);
        @(negedge clk);
        chk("t3_done_pulse", 32'(done), 32'h0);
        chk("t3_busy2", 32'(busy), 32'h0);

        // Test 4: pause for 5 cycles in FETCH at pc=1
        alu_fixed = 4'h0;
        mem[0] = 32'hE2811001; mem[1] = 32'hE2822002; mem[2] = 32'hE0813002;
        @(negedge clk);
        prog_len = 9'd3; start = 1'b1;
        @(negedge clk); start = 1'b0;           // cycle 1 FETCH
        @(negedge clk);                          // cycle 2 LATCH
        @(negedge clk);                          // cycle 3 EXEC
        chk("t4_exec0", 32'(exec_en), 32'h1);
        pause = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);                      // cycles 4..8 held in FETCH
            chk($sformatf("t4_hold_en%0d", i), 32'(imem_en), 32'h0);
            chk($sformatf("t4_hold_addr%0d", i), 32'(imem_addr), 32'h1);
            chk($sformatf("t4_hold_busy%0d", i), 32'(busy), 32'h1);
            chk($sformatf("t4_hold_exec%0d", i), 32'(exec_en), 32'h0);
        end
        pause = 1'b0;
        #1;
        chk("t4_release_en", 32'(imem_en), 32'h1);
        chk("t4_release_addr", 32'(imem_addr), 32'h1);
        @(negedge clk);                          // LATCH
        @(negedge clk);                          // EXEC pc=1
        chk("t4_exec1", 32'(exec_en), 32'h1);
        chk("t4_instr1", Instr, 32'hE2822002);
        repeat (3) @(negedge clk);               // EXEC pc=2
        chk("t4_exec2", 32'(exec_en), 32'h1);
        chk("t4_instr2", Instr, 32'hE0813002);
        @(negedge clk);
        chk("t4_done", 32'(done), 32'h1);
        chk("t4_issued", 32'(issued_cnt), 32'd3);
        chk("t4_skipped", 32'(skipped_cnt), 32'd0);

        // Test 5: reset during EXEC of instruction 2 of 4
        alu_mode = 1'b1;
        mem[0] = 32'hE0100009; mem[1] = 32'hE2811001;
        mem[2] = 32'hE2811002; mem[3] = 32'hE2811003;
        @(negedge clk);
        prog_len = 9'd4; start = 1'b1;
        @(negedge clk); start = 1'b0;            // cycle 1
        repeat (3) @(negedge clk);               // cycle 4
        chk("t5_flags_pre", 32'(flags), 32'h9);
        repeat (2) @(negedge clk);               // cycle 6 EXEC of instr 1
        chk("t5_exec_pre", 32'(exec_en), 32'h1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("t5_busy", 32'(busy), 32'h0);
        chk("t5_exec", 32'(exec_en), 32'h0);
        chk("t5_flags", 32'(flags), 32'h0);
        chk("t5_issued", 32'(issued_cnt), 32'h0);
        chk("t5_skipped", 32'(skipped_cnt), 32'h0);
        chk("t5_done", 32'(done), 32'h0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("t5_idle%0d", i), {30'h0, done, busy}, 32'h0);
        end
        run_prog(4);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("t5_rerun_exec%0d", i), 32'(rec_exec[i]), 32'h1);
            chk($sformatf("t5_rerun_instr%0d", i), rec_instr[i], mem[i]);
        end
        chk("t5_rerun_done", 32'(rec_done[3]), 32'h1);
        chk("t5_rerun_issued", 32'(issued_cnt), 32'd4);

        // Test 6a: start while busy is ignored
        alu_mode = 1'b0;
        mem[0] = 32'hE2811001; mem[1] = 32'hE2822002; mem[2] = 32'hE0813002;
        @(negedge clk);
        prog_len = 9'd3; start = 1'b1;
        @(negedge clk); start = 1'b0;            // cycle 1
        repeat (3) @(negedge clk);               // cycle 4 FETCH pc=1
        chk("t6a_issued_before", 32'(issued_cnt), 32'd1);
        prog_len = 9'd1; start = 1'b1;
        @(negedge clk); start = 1'b0;            // cycle 5
        chk("t6a_issued_kept", 32'(issued_cnt), 32'd1);
        @(negedge clk);                          // cycle 6 EXEC pc=1
        chk("t6a_exec1", 32'(exec_en), 32'h1);
        chk("t6a_instr1", Instr, 32'hE2822002);
        chk("t6a_no_done", 32'(done), 32'h0);
        repeat (3) @(negedge clk);               // cycle 9 EXEC pc=2
        chk("t6a_instr2", Instr, 32'hE0813002);
        @(negedge clk);
        chk("t6a_done", 32'(done), 32'h1);
        chk("t6a_issued", 32'(issued_cnt), 32'd3);

        // Test 6b: condition sweep, one program per NZCV value
        alu_mode = 1'b1;
        for (int f = 0; f < 16; f++) begin
            int n_pass;
            n_pass = 0;
            for (int c = 0; c < 16; c++) begin
                mem[2*c]   = 32'hE0100000 | 32'(f);
                mem[2*c+1] = {4'(c), 28'h0811000};
                if (cond_model(4'(c), 4'(f))) n_pass++;
            end
            run_prog(32);
            for (int c = 0; c < 16; c++) begin
                chk($sformatf("sw_pre_f%0d_c%0d", f, c), 32'(rec_flags[2*c]), 32'(f));
                chk($sformatf("sw_exec_f%0d_c%0d", f, c), 32'(rec_exec[2*c+1]),
                    32'(cond_model(4'(c), 4'(f))));
            end
            chk($sformatf("sw_issued_f%0d", f), 32'(issued_cnt), 32'(16 + n_pass));
            chk($sformatf("sw_skipped_f%0d", f), 32'(skipped_cnt), 32'(16 - n_pass));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
